char_key_decoder: RTL and testbench

PS/2 keyboard receiver and scancode decoder that produces the player movement commands `stepleft`, `stepright` and `stepjump` consumed by the character controller, plus a one-cycle `game_start` pulse. It sits between the board PS/2 pins and the character/game-state logic and runs in the pixel clock domain. It deserialises 11-bit PS/2 device-to-host frames, tracks make/break and extended prefixes, and holds a per-key pressed state.

---
 rtl/char_key_decoder.sv | 170 +++++++++++++++++
 tb/tb_char_key_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/char_key_decoder.sv
// PS/2 device-to-host receiver and scancode decoder producing the character
// movement levels (stepleft/stepright/stepjump) and a game_start pulse on Enter.
module char_key_decoder #(
  parameter int CLK_HZ        = 65_000_000,
  parameter int FRAME_TIMEOUT = 65_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       game_start,
  output logic       frame_err,
  output logic       scan_valid,
  output logic [7:0] scan_code
);

  // Intra-frame stall limit, never allowed to exceed one second of clk.
  localparam logic [16:0] WD_MAX = 17'((FRAME_TIMEOUT < CLK_HZ) ? FRAME_TIMEOUT : CLK_HZ);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic a, d, w, space, enter, left, right, up;
  } keys_t;

  logic        clk_s1, clk_s2, clk_d, data_s1, data_s2, data_d, fall;
  state_t      state, state_next;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par;
  logic [16:0] wd;
  logic        frame_done, frame_good, timeout;
  keys_t       keys, keys_next;
  logic        ext, brk, ext_next, brk_next;
  logic        left_any, right_any;

  // Pins idle high, so the synchronisers reset to 1 to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_d   <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      data_d  <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      data_d  <= data_s2;
      fall    <= clk_d & ~clk_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    timeout    = 1'b0;
    frame_good = (^{shreg, par}) & data_d;
    case (state)
      IDLE:  if (fall && !data_d) state_next = SHIFT;
      SHIFT: begin
        if (fall) begin
          if (bit_cnt == 4'd10) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end
        end else if (wd == WD_MAX) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      wd         <= WD_MAX;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
    end else begin
      if (fall) begin
        if (state == IDLE) begin
          bit_cnt <= 4'd1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt <= 4'd8) shreg <= {data_d, shreg[7:1]};
          if (bit_cnt == 4'd9) par <= data_d;
        end
      end
      // A fall always wins over expiry since it clears the count first.
      if (fall)                               wd <= '0;
      else if (state == IDLE || wd == WD_MAX) wd <= WD_MAX;
      else                                    wd <= wd + 17'd1;
      scan_valid <= frame_done & frame_good;
      frame_err  <= timeout | (frame_done & ~frame_good);
      if (frame_done && frame_good) scan_code <= shreg;
    end
  end

  always_comb begin
    keys_next = keys;
    ext_next  = ext;
    brk_next  = brk;
    if (scan_valid) begin
      case (scan_code)
        8'hE0:   ext_next = 1'b1;
        8'hF0:   brk_next = 1'b1;
        default: begin
          ext_next = 1'b0;
          brk_next = 1'b0;
          // The ext bit is part of the key, so E0 5A (keypad Enter) misses.
          case ({ext, scan_code})
            9'h01C:  keys_next.a     = ~brk;
            9'h023:  keys_next.d     = ~brk;
            9'h01D:  keys_next.w     = ~brk;
            9'h029:  keys_next.space = ~brk;
            9'h05A:  keys_next.enter = ~brk;
            9'h16B:  keys_next.left  = ~brk;
            9'h174:  keys_next.right = ~brk;
            9'h175:  keys_next.up    = ~brk;
            default: ;
          endcase
        end
      endcase
    end
    left_any  = keys_next.a | keys_next.left;
    right_any = keys_next.d | keys_next.right;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys       <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      stepleft   <= 1'b0;
      stepright  <= 1'b0;
      stepjump   <= 1'b0;
      game_start <= 1'b0;
    end else begin
      keys       <= keys_next;
      ext        <= ext_next;
      brk        <= brk_next;
      stepleft   <= left_any & ~right_any;
      stepright  <= right_any & ~left_any;
      stepjump   <= keys_next.w | keys_next.up | keys_next.space;
      game_start <= keys_next.enter & ~keys.enter;
    end
  end

endmodule

// File: tb/tb_char_key_decoder.sv
// Directed bench for char_key_decoder: bit-banged PS/2 frames with
// hand-computed expectations for levels, pulses and latency.
module tb_char_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       stepleft, stepright, stepjump, game_start, frame_err, scan_valid;
  logic [7:0] scan_code;

  int n_cmp = 0;
  int n_mis = 0;
  int sv_cnt = 0, fe_cnt = 0, gs_cnt = 0;
  logic [8:1] sv_h, fe_h, sr_h;

  char_key_decoder #(.FRAME_TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
    .game_start(game_start), .frame_err(frame_err),
    .scan_valid(scan_valid), .scan_code(scan_code)
  );

  always #5 clk = ~clk;

  // Pulse counters: a pulse wider than one cycle counts more than once.
  always @(negedge clk) begin
    if (scan_valid === 1'b1) sv_cnt++;
    if (frame_err === 1'b1)  fe_cnt++;
    if (game_start === 1'b1) gs_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip);
    return {1'b1, ~(^b) ^ flip, b, 1'b0};
  endfunction

  // Sends the first nbits bits of a frame; records 8 post-fall samples of the last bit.
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (8) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        sv_h[k] = scan_valid;
        fe_h[k] = frame_err;
        sr_h[k] = stepright;
      end
      ps2_clk = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1 ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), 11);
  endtask

  task automatic test_reset;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (stepleft !== 1'b0)   begin n_mis++; $display("FAIL reset_stepleft: got %b want 0", stepleft); end
    n_cmp++; if (stepright !== 1'b0)  begin n_mis++; $display("FAIL reset_stepright: got %b want 0", stepright); end
    n_cmp++; if (stepjump !== 1'b0)   begin n_mis++; $display("FAIL reset_stepjump: got %b want 0", stepjump); end
    n_cmp++; if (game_start !== 1'b0) begin n_mis++; $display("FAIL reset_game_start: got %b want 0", game_start); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_mis++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (scan_valid !== 1'b0) begin n_mis++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid); end
    n_cmp++; if (scan_code !== 8'h00) begin n_mis++; $display("FAIL reset_scan_code: got %h want 00", scan_code); end
    rst = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_d_make_break;
    send_byte(8'h23);
    n_cmp++; if (sv_h[4:3] !== 2'b10) begin n_mis++; $display("FAIL d_sv_latency: got E..E+1=%b want 10", sv_h[4:3]); end
    n_cmp++; if (sv_h[5] !== 1'b0)    begin n_mis++; $display("FAIL d_sv_width: got %b want 0 at E+2", sv_h[5]); end
    n_cmp++; if (sr_h[5:4] !== 2'b10) begin n_mis++; $display("FAIL d_step_latency: got E+1..E+2=%b want 10", sr_h[5:4]); end
    n_cmp++; if (scan_code !== 8'h23) begin n_mis++; $display("FAIL d_code1: got %h want 23", scan_code); end
    send_byte(8'hF0);
    n_cmp++; if (scan_code !== 8'hF0) begin n_mis++; $display("FAIL d_code2: got %h want f0", scan_code); end
    n_cmp++; if (stepright !== 1'b1)  begin n_mis++; $display("FAIL d_hold_after_f0: got %b want 1", stepright); end
    send_byte(8'h23);
    n_cmp++; if (sr_h[5:4] !== 2'b01) begin n_mis++; $display("FAIL d_break_latency: got E+1..E+2=%b want 01", sr_h[5:4]); end
    n_cmp++; if (scan_code !== 8'h23) begin n_mis++; $display("FAIL d_code3: got %h want 23", scan_code); end
  endtask

  task automatic test_extended_conflict;
    send_byte(8'hE0); send_byte(8'h6B);
    n_cmp++; if (stepleft !== 1'b1)  begin n_mis++; $display("FAIL ext_left: got %b want 1", stepleft); end
    send_byte(8'h23);
    n_cmp++; if ({stepleft, stepright} !== 2'b00) begin n_mis++; $display("FAIL both_held: got %b want 00", {stepleft, stepright}); end
    send_byte(8'hF0); send_byte(8'h23);
    n_cmp++; if ({stepleft, stepright} !== 2'b10) begin n_mis++; $display("FAIL d_released: got %b want 10", {stepleft, stepright}); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    n_cmp++; if (stepleft !== 1'b0)  begin n_mis++; $display("FAIL ext_left_break: got %b want 0", stepleft); end
  endtask

  task automatic test_parity_error;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(make_frame(8'h29, 1'b1), 11);
    n_cmp++; if (fe_h[4:3] !== 2'b10)   begin n_mis++; $display("FAIL par_err_latency: got %b want 10", fe_h[4:3]); end
    n_cmp++; if (fe_cnt - fe0 !== 1)    begin n_mis++; $display("FAIL par_err_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 0)    begin n_mis++; $display("FAIL par_no_valid: got %0d want 0", sv_cnt - sv0); end
    n_cmp++; if (stepjump !== 1'b0)     begin n_mis++; $display("FAIL par_no_jump: got %b want 0", stepjump); end
    n_cmp++; if (scan_code !== 8'h6B)   begin n_mis++; $display("FAIL par_code_held: got %h want 6b", scan_code); end
    send_byte(8'h29);
    n_cmp++; if (stepjump !== 1'b1)     begin n_mis++; $display("FAIL space_jump: got %b want 1", stepjump); end
    send_byte(8'hF0); send_byte(8'h29);
    n_cmp++; if (stepjump !== 1'b0)     begin n_mis++; $display("FAIL space_release: got %b want 0", stepjump); end
  endtask

  task automatic test_timeout;
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(make_frame(8'h1D, 1'b0), 5);
    repeat (1500) @(posedge clk);
    #1;
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_mis++; $display("FAIL timeout_err: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (sv_cnt - sv0 !== 0) begin n_mis++; $display("FAIL timeout_no_valid: got %0d want 0", sv_cnt - sv0); end
    send_byte(8'h1D);
    n_cmp++; if (scan_code !== 8'h1D) begin n_mis++; $display("FAIL timeout_recover_code: got %h want 1d", scan_code); end
    n_cmp++; if (stepjump !== 1'b1)   begin n_mis++; $display("FAIL timeout_recover_jump: got %b want 1", stepjump); end
    send_byte(8'hF0); send_byte(8'h1D);
    n_cmp++; if (stepjump !== 1'b0)   begin n_mis++; $display("FAIL w_release: got %b want 0", stepjump); end
  endtask

  task automatic test_enter;
    int gs0;
    gs0 = gs_cnt;
    send_byte(8'h5A); send_byte(8'h5A); send_byte(8'h5A);
    n_cmp++; if (gs_cnt - gs0 !== 1) begin n_mis++; $display("FAIL enter_typematic: got %0d want 1", gs_cnt - gs0); end
    send_byte(8'hF0); send_byte(8'h5A); send_byte(8'h5A);
    n_cmp++; if (gs_cnt - gs0 !== 2) begin n_mis++; $display("FAIL enter_repress: got %0d want 2", gs_cnt - gs0); end
    send_byte(8'hF0); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'h5A);
    n_cmp++; if (gs_cnt - gs0 !== 2) begin n_mis++; $display("FAIL keypad_enter: got %0d want 2", gs_cnt - gs0); end
  endtask

  task automatic test_reset_midframe;
    int fe0;
    send_byte(8'h1C);
    n_cmp++; if (stepleft !== 1'b1) begin n_mis++; $display("FAIL a_make: got %b want 1", stepleft); end
    fe0 = fe_cnt;
    send_bits(make_frame(8'hF0, 1'b0), 7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    n_cmp++; if ({stepleft, stepright, stepjump, game_start, frame_err, scan_valid} !== 6'b0)
      begin n_mis++; $display("FAIL midreset_outputs: got %b want 000000", {stepleft, stepright, stepjump, game_start, frame_err, scan_valid}); end
    n_cmp++; if (scan_code !== 8'h00) begin n_mis++; $display("FAIL midreset_code: got %h want 00", scan_code); end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_mis++; $display("FAIL midreset_no_err: got %0d want 0", fe_cnt - fe0); end
    send_byte(8'h1C);
    n_cmp++; if (stepleft !== 1'b1)   begin n_mis++; $display("FAIL post_reset_a: got %b want 1", stepleft); end
    n_cmp++; if (scan_code !== 8'h1C) begin n_mis++; $display("FAIL post_reset_code: got %h want 1c", scan_code); end
  endtask

  initial begin
    test_reset;
    test_d_make_break;
    test_extended_conflict;
    test_parity_error;
    test_timeout;
    test_enter;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
